// File: rtl/multi_digit_updn_cnt_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_digit_updn_cnt_if
// Description : Control/status bundle for the cascaded multi-digit counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_digit_updn_cnt_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    logic                        cin;
    logic                        dir;
    logic [DIGITS*DIGIT_W-1:0]   limit;
    logic [DIGITS*DIGIT_W-1:0]   init_value;
    logic                        pb_clear_op;
    logic [DIGITS*DIGIT_W-1:0]   q;
    logic                        cout;
    logic                        wrap_pulse;
    logic                        zero;

    modport master (
        output cin, dir, limit, init_value, pb_clear_op,
        input  q, cout, wrap_pulse, zero
    );

    modport slave (
        input  cin, dir, limit, init_value, pb_clear_op,
        output q, cout, wrap_pulse, zero
    );
endinterface
`default_nettype wire

// File: rtl/multi_digit_updn_cnt.sv
`default_nettype none
// ============================================================================
// Module      : multi_digit_updn_cnt
// Description : Cascaded up/down counter with per-digit modulus, optional
//               saturation and a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_digit_updn_cnt #(
    parameter int DIGITS   = 4,
    parameter int DIGIT_W  = 4,
    parameter int SATURATE = 0
) (
    input  wire                     clk,
    input  wire                     rst_n,
    multi_digit_updn_cnt_if.slave   bus
);
    localparam int C_W = DIGITS * DIGIT_W;

    logic [C_W-1:0]    r_q;
    logic              r_wrap;
    logic [C_W-1:0]    w_next;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_en;
    logic              w_cout;
    logic              w_sat_hold;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            logic [DIGIT_W-1:0] w_qi;
            logic [DIGIT_W-1:0] w_li;
            logic [DIGIT_W-1:0] w_nxt;

            assign w_qi = r_q[i*DIGIT_W +: DIGIT_W];
            assign w_li = bus.limit[i*DIGIT_W +: DIGIT_W];
            // Up treats any value at or above the limit as terminal so
            // out-of-range digits recover by wrapping to zero.
            assign w_term[i] = bus.dir ? (w_qi == '0) : (w_qi >= w_li);

            if (i == 0) begin : g_first
                assign w_en[i] = bus.cin;
            end else begin : g_chain
                assign w_en[i] = w_en[i-1] & w_term[i-1];
            end

            always_comb begin
                w_nxt = w_qi;
                if (w_en[i]) begin
                    if (!bus.dir) begin
                        w_nxt = w_term[i] ? '0 : w_qi + 1'b1;
                    end else if (w_qi == '0 || w_qi > w_li) begin
                        w_nxt = w_li;
                    end else begin
                        w_nxt = w_qi - 1'b1;
                    end
                end
            end

            assign w_next[i*DIGIT_W +: DIGIT_W] = w_nxt;
        end
    endgenerate

    assign w_cout     = w_en[DIGITS-1] & w_term[DIGITS-1];
    assign w_sat_hold = (SATURATE != 0) & w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (bus.pb_clear_op) begin
            r_q    <= bus.init_value;
            r_wrap <= 1'b0;
        end else if (w_sat_hold) begin
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_next;
            r_wrap <= w_cout;
        end
    end

    assign bus.q          = r_q;
    assign bus.cout       = w_cout;
    assign bus.wrap_pulse = r_wrap;
    assign bus.zero       = (r_q == '0);
endmodule
`default_nettype wire

// File: tb/tb_multi_digit_updn_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_digit_updn_cnt
// Description : Directed scoreboard bench, 2-digit 0..59 counter in wrap and
//               saturating builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_digit_updn_cnt;
    logic clk;
    logic rst_n;

    multi_digit_updn_cnt_if #(.DIGITS(2), .DIGIT_W(4)) bus_a ();
    multi_digit_updn_cnt_if #(.DIGITS(2), .DIGIT_W(4)) bus_b ();

    multi_digit_updn_cnt #(.DIGITS(2), .DIGIT_W(4), .SATURATE(0)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    multi_digit_updn_cnt #(.DIGITS(2), .DIGIT_W(4), .SATURATE(1)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        bit         sel;
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the combinational outputs before the
    // edge, and compare the registered outputs just after it.
    task automatic step(input bit sel, input logic cin, input logic dir,
                        input logic clr, input logic [7:0] init,
                        input logic [7:0] exp_q, input logic exp_wrap,
                        input logic exp_cout, input logic exp_zero,
                        input string tag);
        exp_t e;
        if (!sel) begin
            bus_a.cin = cin; bus_a.dir = dir; bus_a.pb_clear_op = clr; bus_a.init_value = init;
        end else begin
            bus_b.cin = cin; bus_b.dir = dir; bus_b.pb_clear_op = clr; bus_b.init_value = init;
        end
        sb.push_back('{tag, sel, exp_q, exp_wrap});
        #1;
        chk({tag, "_cout"}, {7'd0, sel ? bus_b.cout : bus_a.cout}, {7'd0, exp_cout});
        chk({tag, "_zero"}, {7'd0, sel ? bus_b.zero : bus_a.zero}, {7'd0, exp_zero});
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({e.tag, "_q"}, e.sel ? bus_b.q : bus_a.q, e.q);
        chk({e.tag, "_wrap"}, {7'd0, e.sel ? bus_b.wrap_pulse : bus_a.wrap_pulse}, {7'd0, e.wrap});
        if (!sel) chk({tag, "_sat_wrap"}, {7'd0, bus_b.wrap_pulse}, 8'd0);
        if (!sel) bus_a.pb_clear_op = 1'b0; else bus_b.pb_clear_op = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        rst_n = 1'b0;
        bus_a.cin = 0; bus_a.dir = 0; bus_a.pb_clear_op = 0; bus_a.init_value = '0; bus_a.limit = 8'h59;
        bus_b.cin = 0; bus_b.dir = 0; bus_b.pb_clear_op = 0; bus_b.init_value = '0; bus_b.limit = 8'h59;
        #12;
        chk("rst_q", bus_a.q, 8'h00);
        chk("rst_wrap", {7'd0, bus_a.wrap_pulse}, 8'd0);
        chk("rst_zero", {7'd0, bus_a.zero}, 8'd1);
        chk("rst_sat_q", bus_b.q, 8'h00);
        rst_n = 1'b1;

        // Up through the full 00..59 range and past the wrap.
        for (int k = 0; k < 61; k++) begin
            v = k % 60;
            step(0, 1, 0, 0, 8'h00, bcd((v + 1) % 60), v == 59, v == 59, v == 0, "up");
        end

        // Load 59 and count down through 00 and back to 59.
        step(0, 1, 1, 1, 8'h59, 8'h59, 0, 0, 0, "dn_load");
        for (int k = 0; k < 61; k++) begin
            v = (59 - k + 60) % 60;
            step(0, 1, 1, 0, 8'h00, bcd((v + 59) % 60), v == 0, v == 0, v == 0, "dn");
        end

        // Load beats count.
        step(0, 0, 0, 1, 8'h33, 8'h33, 0, 0, 0, "ld33");
        step(0, 1, 0, 1, 8'h12, 8'h12, 0, 0, 0, "clr_prio");

        // Out-of-range low digit.
        step(0, 0, 0, 1, 8'h0C, 8'h0C, 0, 0, 0, "ld0c_a");
        step(0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0, "oor_up");
        step(0, 0, 0, 1, 8'h0C, 8'h0C, 0, 0, 0, "ld0c_b");
        step(0, 1, 1, 0, 8'h00, 8'h09, 0, 0, 0, "oor_dn");

        // Saturating build holds at 59.
        step(1, 0, 0, 1, 8'h58, 8'h58, 0, 0, 1, "sat_ld");
        step(1, 1, 0, 0, 8'h00, 8'h59, 0, 0, 0, "sat_59");
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 8'h00, 8'h59, 0, 1, 0, "sat_hold");
        bus_b.cin = 1'b0;

        // Asynchronous reset mid-count.
        step(0, 0, 0, 1, 8'h46, 8'h46, 0, 0, 0, "ld46");
        step(0, 1, 0, 0, 8'h00, 8'h47, 0, 0, 0, "to47");
        rst_n = 1'b0;
        #2;
        chk("arst_q", bus_a.q, 8'h00);
        chk("arst_wrap", {7'd0, bus_a.wrap_pulse}, 8'd0);
        @(posedge clk); #1;
        chk("arst_hold_q", bus_a.q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
